usb_hpi_sequencer: RTL and testbench

//  Sequences single 16-bit host-port (HPI) transactions to the USB OTG controller chip, replacing software bit-banging of the OTG data/control PIOs.

---
 rtl/usb_hpi_pkg.sv | 17 +
 rtl/usb_hpi_sequencer.sv | 151 +++++++++++++++
 tb/tb_usb_hpi_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_hpi_pkg.sv
// Shared definitions for the USB OTG host-port sequencer: FSM state encoding and HPI register map.
package usb_hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/usb_hpi_sequencer.sv
// Sequences one 16-bit HPI read/write to the USB OTG chip with parameterised setup/strobe/hold/turnaround.
// Latency: SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from accept to rsp_valid; all outputs registered.
// Backpressure: req_ready only in IDLE; requests presented while busy are ignored, never queued.
module usb_hpi_sequencer
  import usb_hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 2,
  parameter int CW         = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
);

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    addr_q;
  logic [15:0]   wdata_q;
  logic          req_ready_q, rsp_valid_q, busy_q;
  logic          cs_n_q, rd_n_q, wr_n_q, oe_q;
  logic [15:0]   rdata_q;
  logic          accept;
  logic          active_d;

  assign accept   = req_valid & req_ready_q;
  assign wr_d     = accept ? req_write : wr_q;
  assign active_d = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          // Only reads need bus turnaround: the chip is still releasing the data pins.
          if (!wr_q && (TURN_CYC > 0)) begin
            state_d = ST_TURN;
            cnt_d   = TURN_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 16'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= 16'd0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_STROBE && cnt_q == '0 && !wr_q) begin
        rdata_q <= otg_data_in;
      end
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= (state_d == ST_HOLD) && (cnt_d == '0);
      cs_n_q      <= !active_d;
      rd_n_q      <= !((state_d == ST_STROBE) && !wr_d);
      wr_n_q      <= !((state_d == ST_STROBE) && wr_d);
      oe_q        <= active_d && wr_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign busy         = busy_q;
  assign otg_addr     = addr_q;
  assign otg_cs_n     = cs_n_q;
  assign otg_rd_n     = rd_n_q;
  assign otg_wr_n     = wr_n_q;
  assign otg_data_out = wdata_q;
  assign otg_data_oe  = oe_q;

endmodule

// File: tb/tb_usb_hpi_sequencer.sv
// Directed bench for usb_hpi_sequencer: default-timing instance plus a minimum-timing instance,
// with a small register-file model of the OTG chip behind each.
module tb_usb_hpi_sequencer;
  import usb_hpi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write, b_valid;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;

  logic        req_ready, rsp_valid, busy, otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe;
  logic [15:0] rsp_rdata, otg_data_out, otg_data_in;
  logic [1:0]  otg_addr;

  logic        b_ready, b_rsp_valid, b_busy, b_cs_n, b_rd_n, b_wr_n, b_oe;
  logic [15:0] b_rdata, b_dout, b_din;
  logic [1:0]  b_addr;

  logic [15:0] mem [4];
  int          n_checks = 0;
  int          n_fail = 0;
  int          overlap_cnt = 0;
  int          glitch_cnt = 0;
  logic        prev_cs_n = 1'b1;
  logic [1:0]  prev_addr = 2'd0;
  logic [15:0] prev_dout = 16'd0;

  usb_hpi_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
    .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
  );

  usb_hpi_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(0), .CW(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy),
    .otg_addr(b_addr), .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n),
    .otg_data_out(b_dout), .otg_data_oe(b_oe), .otg_data_in(b_din)
  );

  // Chip model: drives register contents only while its read strobe is low.
  assign otg_data_in = !otg_rd_n ? mem[otg_addr] : 16'h0000;
  assign b_din       = !b_rd_n   ? mem[b_addr]   : 16'h0000;

  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 16'hBEEF;
      mem[1] <= 16'h0000;
      mem[2] <= 16'h0000;
      mem[3] <= 16'hC0DE;
    end else begin
      if (!otg_wr_n) mem[otg_addr] <= otg_data_out;
      if (!b_wr_n)   mem[b_addr]   <= b_dout;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (!otg_rd_n && (!otg_wr_n || otg_data_oe)) overlap_cnt <= overlap_cnt + 1;
      if (!otg_cs_n && !prev_cs_n && (otg_addr != prev_addr || otg_data_out != prev_dout))
        glitch_cnt <= glitch_cnt + 1;
    end
    prev_cs_n <= otg_cs_n;
    prev_addr <= otg_addr;
    prev_dout <= otg_data_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the default instance and records cycles T+1..T+9 (bit k-1 = cycle T+k).
  task automatic run_vec(input logic wr, input logic [1:0] a, input logic [15:0] d,
                         output logic [8:0] v_cs, output logic [8:0] v_rd, output logic [8:0] v_wr,
                         output logic [8:0] v_oe, output logic [8:0] v_rv, output logic [8:0] v_rdy,
                         output logic [8:0] v_busy, output logic [15:0] rd6, output logic [1:0] a6);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    rd6 = 16'd0;
    a6  = 2'd0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) begin
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~a;
        req_wdata = ~d;
      end
      v_cs[k-1]   = otg_cs_n;
      v_rd[k-1]   = otg_rd_n;
      v_wr[k-1]   = otg_wr_n;
      v_oe[k-1]   = otg_data_oe;
      v_rv[k-1]   = rsp_valid;
      v_rdy[k-1]  = req_ready;
      v_busy[k-1] = busy;
      if (k == 6) begin
        rd6 = rsp_rdata;
        a6  = otg_addr;
      end
    end
  endtask

  initial begin
    logic [8:0]  vc, vr, vw, vo, vv, vy, vb;
    logic [15:0] r6, d;
    logic [1:0]  a6, a;
    logic        wr;
    logic [15:0] ref_mem [4];
    int          n, acc0, acc1, bad, rv_cnt, lat, lat_err, rd_err, to_err, mem_err;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 16'd0; b_valid = 1'b0;
    repeat (3) tick();
    check("rst_ctl", 32'({req_ready, rsp_valid, busy, b_ready, b_busy}), 32'h0);
    check("rst_strobes", 32'({otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe}), 32'hE);
    check("rst_bus", {otg_data_out, rsp_rdata}, 32'h0);
    check("rst_addr", 32'(otg_addr), 32'h0);
    reset = 1'b0;
    tick();
    check("rst_ready_after", 32'({req_ready, busy}), 32'h2);

    // Write ADDRESS register
    run_vec(1'b1, HPI_ADDRESS, 16'h1234, vc, vr, vw, vo, vv, vy, vb, r6, a6);
    check("t1_cs_n", 32'(vc), 32'h1C0);
    check("t1_wr_n", 32'(vw), 32'h1E1);
    check("t1_rd_n", 32'(vr), 32'h1FF);
    check("t1_oe", 32'(vo), 32'h03F);
    check("t1_rsp_valid", 32'(vv), 32'h020);
    check("t1_ready", 32'(vy), 32'h1C0);
    check("t1_busy", 32'(vb), 32'h03F);
    check("t1_addr", 32'(a6), 32'h2);
    check("t1_mem", 32'(mem[2]), 32'h1234);

    // Read DATA register
    run_vec(1'b0, HPI_DATA, 16'h0F0F, vc, vr, vw, vo, vv, vy, vb, r6, a6);
    check("t2_cs_n", 32'(vc), 32'h1C0);
    check("t2_rd_n", 32'(vr), 32'h1E1);
    check("t2_wr_n", 32'(vw), 32'h1FF);
    check("t2_oe", 32'(vo), 32'h000);
    check("t2_rsp_valid", 32'(vv), 32'h020);
    check("t2_ready", 32'(vy), 32'h100);
    check("t2_busy", 32'(vb), 32'h0FF);
    check("t2_rdata", 32'(r6), 32'hBEEF);

    // Back-to-back with req_valid held; inputs flip to a read as soon as the write is accepted
    req_valid = 1'b1; req_write = 1'b1; req_addr = HPI_MAILBOX; req_wdata = 16'hAAAA;
    acc0 = -1; acc1 = -1; bad = 0; r6 = 16'd0;
    for (int c = 0; c < 30; c++) begin
      if (req_ready && req_valid) begin
        if (acc0 < 0) acc0 = c;
        else if (acc1 < 0) acc1 = c;
      end
      tick();
      if (acc1 >= 0) begin
        req_valid = 1'b0;
      end else if (acc0 >= 0) begin
        req_write = 1'b0; req_addr = HPI_DATA; req_wdata = 16'h5555;
        if (!otg_cs_n && (otg_addr != HPI_MAILBOX || otg_data_out != 16'hAAAA)) bad++;
      end
      if (acc1 >= 0 && rsp_valid) r6 = rsp_rdata;
    end
    check("t3_gap", 32'(acc1 - acc0), 32'd7);
    check("t3_stable", 32'(bad), 32'd0);
    check("t3_wmem", 32'(mem[1]), 32'hAAAA);
    check("t3_mem0", 32'(mem[0]), 32'hBEEF);
    check("t3_rdata", 32'(r6), 32'hBEEF);

    // Reset in the middle of a write strobe
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = HPI_STATUS; req_wdata = 16'h7777;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("t4_in_strobe", 32'({otg_wr_n, otg_cs_n}), 32'h0);
    reset = 1'b1;
    tick();
    check("t4_rst_outs", 32'({otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe, rsp_valid, req_ready, busy}),
          32'b1110000);
    reset = 1'b0;
    tick();
    check("t4_ready", 32'(req_ready), 32'h1);
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) rv_cnt++;
      tick();
    end
    check("t4_no_rsp", 32'(rv_cnt), 32'd0);

    // Minimum-timing instance, read STATUS
    req_write = 1'b0; req_addr = HPI_STATUS; req_wdata = 16'h0000;
    n = 0;
    while (!b_ready && n < 20) begin
      tick();
      n++;
    end
    b_valid = 1'b1;
    r6 = 16'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        b_valid  = 1'b0;
        req_addr = HPI_DATA;
      end
      vc[k-1] = b_cs_n;
      vr[k-1] = b_rd_n;
      vv[k-1] = b_rsp_valid;
      vy[k-1] = b_ready;
      vo[k-1] = b_oe;
      vb[k-1] = b_busy;
      if (k == 3) r6 = b_rdata;
    end
    check("t5_cs_n", 32'(vc[4:0]), 32'h18);
    check("t5_rd_n", 32'(vr[4:0]), 32'h1D);
    check("t5_rsp_valid", 32'(vv[4:0]), 32'h04);
    check("t5_ready", 32'(vy[4:0]), 32'h18);
    check("t5_oe", 32'(vo[4:0]), 32'h00);
    check("t5_busy", 32'(vb[4:0]), 32'h07);
    check("t5_rdata", 32'(r6), 32'hC0DE);

    // Random traffic against a reference register file
    ref_mem[0] = 16'hBEEF; ref_mem[1] = 16'h0000; ref_mem[2] = 16'h0000; ref_mem[3] = 16'hC0DE;
    lat_err = 0; rd_err = 0; to_err = 0; mem_err = 0;
    for (int i = 0; i < 1000; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      n = 0;
      while (!req_ready && n < 20) begin
        tick();
        n++;
      end
      if (!req_ready) to_err++;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0; req_wdata = ~d; req_addr = ~a;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
        tick();
        lat++;
      end
      if (lat != 6) lat_err++;
      if (!wr && rsp_rdata != ref_mem[a]) rd_err++;
      if (wr) ref_mem[a] = d;
    end
    tick();
    for (int j = 0; j < 4; j++) if (mem[j] != ref_mem[j]) mem_err++;
    check("t6_timeout", 32'(to_err), 32'd0);
    check("t6_latency", 32'(lat_err), 32'd0);
    check("t6_rdata", 32'(rd_err), 32'd0);
    check("t6_chip_mem", 32'(mem_err), 32'd0);
    check("t6_overlap", 32'(overlap_cnt), 32'd0);
    check("t6_glitch", 32'(glitch_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
